// File: rtl/fpu_op_issuer_if.sv
// Operand/result channels between the issuer and a two-operand FPU unit.
// Each channel uses a stb/ack pair; a transfer happens on a clock edge
// where both are high.
interface fpu_op_issuer_if;
  logic [31:0] fpu_a;
  logic        fpu_a_stb;
  logic        fpu_a_ack;
  logic [31:0] fpu_b;
  logic        fpu_b_stb;
  logic        fpu_b_ack;
  logic [31:0] fpu_z;
  logic        fpu_z_stb;
  logic        fpu_z_ack;
  logic        fpu_rst;

  // Issuer side: drives operands and the Z acknowledge.
  modport master (
    output fpu_a, fpu_a_stb,
    input  fpu_a_ack,
    output fpu_b, fpu_b_stb,
    input  fpu_b_ack,
    input  fpu_z, fpu_z_stb,
    output fpu_z_ack,
    output fpu_rst
  );

  // FPU side: accepts operands and returns Z.
  modport slave (
    input  fpu_a, fpu_a_stb,
    output fpu_a_ack,
    input  fpu_b, fpu_b_stb,
    output fpu_b_ack,
    output fpu_z, fpu_z_stb,
    input  fpu_z_ack,
    input  fpu_rst
  );
endinterface

// File: rtl/fpu_op_issuer.sv
// Initiator for a stb/ack two-operand FPU: sends A, then B, collects Z,
// classifies it and returns it with status flags. A watchdog aborts a
// transaction that stalls too long and pulses a reset into the FPU.
module fpu_op_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024  // 0 disables the watchdog
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] res_z,
  output logic [4:0]  res_flags,
  output logic        res_valid,
  output logic        busy,
  fpu_op_issuer_if.master fpu
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] wd_count_reg, wd_count_next;
  logic [31:0] fpu_a_reg, fpu_a_next;
  logic [31:0] fpu_b_reg, fpu_b_next;
  logic        fpu_a_stb_reg, fpu_a_stb_next;
  logic        fpu_b_stb_reg, fpu_b_stb_next;
  logic        fpu_z_ack_reg, fpu_z_ack_next;
  logic        fpu_rst_reg, fpu_rst_next;
  logic [31:0] res_z_reg, res_z_next;
  logic [4:0]  res_flags_reg, res_flags_next;

  logic a_xfer, b_xfer, z_xfer, in_flight, wd_expired;

  // {nan, inf, zero, denorm} of an IEEE-754 single.
  function automatic logic [3:0] classify(input logic [31:0] z);
    logic exp_ones, exp_zero, man_zero;
    exp_ones = (z[30:23] == 8'hFF);
    exp_zero = (z[30:23] == 8'h00);
    man_zero = (z[22:0] == 23'd0);
    return {exp_ones & ~man_zero, exp_ones & man_zero,
            exp_zero & man_zero, exp_zero & ~man_zero};
  endfunction

  assign a_xfer    = (state_reg == SEND_A) && fpu_a_stb_reg && fpu.fpu_a_ack;
  assign b_xfer    = (state_reg == SEND_B) && fpu_b_stb_reg && fpu.fpu_b_ack;
  assign z_xfer    = (state_reg == WAIT_Z) && fpu_z_ack_reg && fpu.fpu_z_stb;
  assign in_flight = (state_reg == SEND_A) || (state_reg == SEND_B) ||
                     (state_reg == WAIT_Z);
  // The count holds the cycles already spent before this edge, so the
  // edge closing cycle TIMEOUT_CYCLES sees TIMEOUT_CYCLES-1. A transfer
  // on that same edge takes priority over the abort.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && in_flight &&
                      (wd_count_reg >= TIMEOUT_CYCLES - 32'd1) &&
                      !(a_xfer || b_xfer || z_xfer);

  assign cmd_ready     = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign res_valid     = (state_reg == DONE);
  assign res_z         = res_z_reg;
  assign res_flags     = res_flags_reg;
  assign fpu.fpu_a     = fpu_a_reg;
  assign fpu.fpu_b     = fpu_b_reg;
  assign fpu.fpu_a_stb = fpu_a_stb_reg;
  assign fpu.fpu_b_stb = fpu_b_stb_reg;
  assign fpu.fpu_z_ack = fpu_z_ack_reg;
  assign fpu.fpu_rst   = fpu_rst_reg;

  // State and registered outputs; reset clears everything back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wd_count_reg  <= '0;
      fpu_a_reg     <= '0;
      fpu_b_reg     <= '0;
      fpu_a_stb_reg <= 1'b0;
      fpu_b_stb_reg <= 1'b0;
      fpu_z_ack_reg <= 1'b0;
      fpu_rst_reg   <= 1'b0;
      res_z_reg     <= '0;
      res_flags_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wd_count_reg  <= wd_count_next;
      fpu_a_reg     <= fpu_a_next;
      fpu_b_reg     <= fpu_b_next;
      fpu_a_stb_reg <= fpu_a_stb_next;
      fpu_b_stb_reg <= fpu_b_stb_next;
      fpu_z_ack_reg <= fpu_z_ack_next;
      fpu_rst_reg   <= fpu_rst_next;
      res_z_reg     <= res_z_next;
      res_flags_reg <= res_flags_next;
    end
  end

  // Next-state: advance on each channel transfer, abort to DONE on expiry.
  always_comb begin
    state_next = state_reg;
    if (wd_expired) begin
      state_next = DONE;
    end else begin
      case (state_reg)
        IDLE:    if (cmd_valid) state_next = SEND_A;
        SEND_A:  if (a_xfer)    state_next = SEND_B;
        SEND_B:  if (b_xfer)    state_next = WAIT_Z;
        WAIT_Z:  if (z_xfer)    state_next = DONE;
        DONE:                   state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  // Output next-values: strobes hand over channel to channel, result is
  // captured and classified on the Z transfer, watchdog counts in flight.
  always_comb begin
    fpu_a_next     = fpu_a_reg;
    fpu_b_next     = fpu_b_reg;
    fpu_a_stb_next = fpu_a_stb_reg;
    fpu_b_stb_next = fpu_b_stb_reg;
    fpu_z_ack_next = fpu_z_ack_reg;
    fpu_rst_next   = 1'b0;
    res_z_next     = res_z_reg;
    res_flags_next = res_flags_reg;
    wd_count_next  = wd_count_reg;

    if (in_flight && (wd_count_reg < TIMEOUT_CYCLES))
      wd_count_next = wd_count_reg + 32'd1;

    if (wd_expired) begin
      fpu_a_stb_next = 1'b0;
      fpu_b_stb_next = 1'b0;
      fpu_z_ack_next = 1'b0;
      fpu_rst_next   = 1'b1;
      res_z_next     = '0;
      res_flags_next = 5'b10000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            fpu_a_next     = cmd_a;
            fpu_b_next     = cmd_b;
            fpu_a_stb_next = 1'b1;
            wd_count_next  = '0;
          end
        end
        SEND_A: begin
          if (a_xfer) begin
            fpu_a_stb_next = 1'b0;
            fpu_b_stb_next = 1'b1;
          end
        end
        SEND_B: begin
          if (b_xfer) begin
            fpu_b_stb_next = 1'b0;
            fpu_z_ack_next = 1'b1;
          end
        end
        WAIT_Z: begin
          if (z_xfer) begin
            res_z_next     = fpu.fpu_z;
            res_flags_next = {1'b0, classify(fpu.fpu_z)};
            fpu_z_ack_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_issuer.sv
// Bench for fpu_op_issuer: a stub divider with programmable ack/result
// delays drives the main instance from a vector table; two extra instances
// with a silent FPU exercise the watchdog (16 cycles) and its disabled mode.
module tb_fpu_op_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int applied = 0;
  int miscompares = 0;

  // ---------------- main instance with stub divider ----------------
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, res_valid, busy;
  logic [31:0] res_z;
  logic [4:0]  res_flags;
  fpu_op_issuer_if fm();

  fpu_op_issuer dut (
    .clk(clk), .rst(rst), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .res_z(res_z), .res_flags(res_flags),
    .res_valid(res_valid), .busy(busy), .fpu(fm.master)
  );

  int stub_a_dly = 0, stub_b_dly = 0, stub_z_dly = 0;
  logic [31:0] stub_z = '0;
  int a_cnt = 0, b_cnt = 0, z_cnt = 0, a_xfers = 0;
  logic z_pending = 1'b0;

  assign fm.fpu_a_ack = fm.fpu_a_stb && (a_cnt >= stub_a_dly);
  assign fm.fpu_b_ack = fm.fpu_b_stb && (b_cnt >= stub_b_dly);
  assign fm.fpu_z_stb = z_pending && (z_cnt >= stub_z_dly);
  assign fm.fpu_z     = stub_z;

  // Stub FPU: counts strobe-high cycles before acking, returns Z later.
  always @(posedge clk) begin
    if (rst || fm.fpu_rst) begin
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; z_pending <= 1'b0;
    end else begin
      if (fm.fpu_a_stb && fm.fpu_a_ack) begin a_cnt <= 0; a_xfers <= a_xfers + 1; end
      else if (fm.fpu_a_stb) a_cnt <= a_cnt + 1;
      if (fm.fpu_b_stb && fm.fpu_b_ack) begin b_cnt <= 0; z_pending <= 1'b1; z_cnt <= 0; end
      else if (fm.fpu_b_stb) b_cnt <= b_cnt + 1;
      if (fm.fpu_z_stb && fm.fpu_z_ack) z_pending <= 1'b0;
      else if (z_pending && !fm.fpu_z_stb) z_cnt <= z_cnt + 1;
    end
  end

  // Protocol monitor: no cross-channel overlap, strobe/data held until transfer.
  logic seen_rst = 1'b0;
  logic p_a_stb = 1'b0, p_a_ack = 1'b0, p_b_stb = 1'b0, p_b_ack = 1'b0;
  logic [31:0] p_a = '0, p_b = '0;
  int mon_fails = 0;
  always @(posedge clk) seen_rst <= rst;
  always @(negedge clk) begin
    if (!seen_rst) begin
      if ((32'(fm.fpu_a_stb) + 32'(fm.fpu_b_stb) + 32'(fm.fpu_z_ack)) > 1) begin
        mon_fails <= mon_fails + 1;
        $display("FAIL overlap: a_stb=%b b_stb=%b z_ack=%b required at most one",
                 fm.fpu_a_stb, fm.fpu_b_stb, fm.fpu_z_ack);
      end
      if (p_a_stb && !p_a_ack && (!fm.fpu_a_stb || fm.fpu_a !== p_a)) begin
        mon_fails <= mon_fails + 1;
        $display("FAIL a_stable: stb=%b a=%h required stb=1 a=%h", fm.fpu_a_stb, fm.fpu_a, p_a);
      end
      if (p_b_stb && !p_b_ack && (!fm.fpu_b_stb || fm.fpu_b !== p_b)) begin
        mon_fails <= mon_fails + 1;
        $display("FAIL b_stable: stb=%b b=%h required stb=1 b=%h", fm.fpu_b_stb, fm.fpu_b, p_b);
      end
    end
    p_a_stb <= fm.fpu_a_stb; p_a_ack <= fm.fpu_a_ack; p_a <= fm.fpu_a;
    p_b_stb <= fm.fpu_b_stb; p_b_ack <= fm.fpu_b_ack; p_b <= fm.fpu_b;
  end

  // ---------------- watchdog instances with a silent FPU ----------------
  logic [31:0] t_cmd_a = 32'h3F800000, t_cmd_b = 32'h40000000;
  logic        t_cmd_valid = 1'b0;
  logic        t16_ready, t16_valid, t16_busy, t0_ready, t0_valid, t0_busy;
  logic [31:0] t16_z, t0_z;
  logic [4:0]  t16_flags, t0_flags;
  fpu_op_issuer_if ft16();
  fpu_op_issuer_if ft0();
  assign ft16.fpu_a_ack = 1'b0;  assign ft0.fpu_a_ack = 1'b0;
  assign ft16.fpu_b_ack = 1'b0;  assign ft0.fpu_b_ack = 1'b0;
  assign ft16.fpu_z_stb = 1'b0;  assign ft0.fpu_z_stb = 1'b0;
  assign ft16.fpu_z     = '0;    assign ft0.fpu_z     = '0;

  fpu_op_issuer #(.TIMEOUT_CYCLES(16)) dut_t16 (
    .clk(clk), .rst(rst), .cmd_a(t_cmd_a), .cmd_b(t_cmd_b), .cmd_valid(t_cmd_valid),
    .cmd_ready(t16_ready), .res_z(t16_z), .res_flags(t16_flags),
    .res_valid(t16_valid), .busy(t16_busy), .fpu(ft16.master)
  );
  fpu_op_issuer #(.TIMEOUT_CYCLES(0)) dut_t0 (
    .clk(clk), .rst(rst), .cmd_a(t_cmd_a), .cmd_b(t_cmd_b), .cmd_valid(t_cmd_valid),
    .cmd_ready(t0_ready), .res_z(t0_z), .res_flags(t0_flags),
    .res_valid(t0_valid), .busy(t0_busy), .fpu(ft0.master)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b, z;
    int          a_dly, b_dly, z_dly;
    logic [31:0] exp_z;
    logic [4:0]  exp_flags;
    bit          hold;
  } vec_t;

  // Apply one command through the stub FPU and check the result.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit got, mid_ok;
    int x0;
    @(negedge clk);
    stub_a_dly = v.a_dly; stub_b_dly = v.b_dly; stub_z_dly = v.z_dly; stub_z = v.z;
    cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
    x0 = a_xfers;
    @(negedge clk);
    if (!v.hold) cmd_valid = 1'b0;
    n = 1; got = 1'b0; mid_ok = 1'b1;
    while (n < 200 && !got) begin
      if (res_valid) got = 1'b1;
      else begin
        if (cmd_ready !== 1'b0 || busy !== 1'b1) mid_ok = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    cmd_valid = 1'b0;
    check($sformatf("v%0d_res_valid_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_latency", idx), n, 4 + v.a_dly + v.b_dly + v.z_dly);
    check($sformatf("v%0d_busy_while_in_flight", idx), 32'(mid_ok), 32'd1);
    check($sformatf("v%0d_res_z", idx), res_z, v.exp_z);
    check($sformatf("v%0d_flags", idx), 32'(res_flags), 32'(v.exp_flags));
    $display("vec %0d: a=%h b=%h -> z=%h flags=%b latency=%0d", idx, v.a, v.b, res_z, res_flags, n);
    @(negedge clk);
    check($sformatf("v%0d_after_{valid,busy,ready}", idx),
          32'({res_valid, busy, cmd_ready}), 32'b001);
    check($sformatf("v%0d_a_transfers", idx), a_xfers - x0, 1);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    bit ok;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 32'h40400000, 5'b00000, 1'b0};
    vecs[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 0, 32'h7F800000, 5'b00100, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'hFFC00000, 0, 0, 0, 32'hFFC00000, 5'b01000, 1'b0};
    vecs[3] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5, 0, 7, 32'h3EAAAAAB, 5'b00000, 1'b0};
    vecs[4] = '{32'h00800000, 32'h40000000, 32'h00400000, 1, 3, 2, 32'h00400000, 5'b00001, 1'b0};
    vecs[5] = '{32'h00000001, 32'h40000000, 32'h00000000, 0, 2, 0, 32'h00000000, 5'b00010, 1'b0};
    vecs[6] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 2, 1, 3, 32'hC0400000, 5'b00000, 1'b1};
    vecs[7] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 0, 1, 32'h7F800000, 5'b00100, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready_busy_valid", 32'({cmd_ready, busy, res_valid}), 32'b100);
    rst = 1'b0;
    @(negedge clk);
    check("reset_res_z", res_z, 32'd0);
    check("reset_flags", 32'(res_flags), 32'd0);
    check("reset_fpu_ctl", 32'({fm.fpu_a_stb, fm.fpu_b_stb, fm.fpu_z_ack, fm.fpu_rst}), 32'd0);
    check("reset_fpu_a", fm.fpu_a, 32'd0);

    // Table-driven transactions
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while waiting for Z
    @(negedge clk);
    stub_a_dly = 0; stub_b_dly = 0; stub_z_dly = 50; stub_z = 32'h12345678;
    cmd_a = 32'h41200000; cmd_b = 32'h40A00000; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!fm.fpu_z_ack && n < 20) begin @(negedge clk); n++; end
    check("rst_reached_wait_z", 32'(fm.fpu_z_ack), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready_busy_valid", 32'({cmd_ready, busy, res_valid}), 32'b100);
    check("rst_mid_fpu_ctl", 32'({fm.fpu_a_stb, fm.fpu_b_stb, fm.fpu_z_ack, fm.fpu_rst}), 32'd0);
    check("rst_mid_data", fm.fpu_a | fm.fpu_b | res_z | 32'(res_flags), 32'd0);
    $display("reset in WAIT_Z applied after %0d cycles", n);
    run_vec(vecs[0], 8);

    // Watchdog: 16-cycle instance aborts, disabled instance stays busy
    @(negedge clk);
    t_cmd_valid = 1'b1;
    @(negedge clk);
    t_cmd_valid = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (!(t16_busy && ft16.fpu_a_stb && !ft16.fpu_rst && !t16_valid)) ok = 1'b0;
      @(negedge clk);
    end
    check("wd16_waiting_in_send_a", 32'(ok), 32'd1);
    check("wd16_abort_{valid,rst,a_stb}", 32'({t16_valid, ft16.fpu_rst, ft16.fpu_a_stb}), 32'b110);
    check("wd16_res_z", t16_z, 32'd0);
    check("wd16_flags", 32'(t16_flags), 32'b10000);
    $display("watchdog 16: z=%h flags=%b", t16_z, t16_flags);
    @(negedge clk);
    check("wd16_after_{valid,rst,busy,ready}",
          32'({t16_valid, ft16.fpu_rst, t16_busy, t16_ready}), 32'b0001);
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!(t0_busy && ft0.fpu_a_stb && !ft0.fpu_rst && !t0_valid && !t0_ready)) ok = 1'b0;
      @(negedge clk);
    end
    check("wd0_stays_busy", 32'(ok), 32'd1);
    $display("watchdog 0: busy=%b after 118 cycles", t0_busy);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wd0_reset_ready", 32'({t0_ready, t0_busy}), 32'b10);

    check("protocol_violations", mon_fails, 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "time bound");
  end

endmodule
